// File: rtl/bus_trace_buffer.sv
// Passive CPU bus observer: detects read/write transactions, optionally filters
// them by address window, timestamps them and queues them for a pop-style drain.
module bus_trace_buffer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TS_WIDTH = 16,
  parameter int unsigned WRAP     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               addr_in,
  input  logic [1:0]                ctrl_in,
  input  logic [15:0]               data_in,
  input  logic                      arm,
  input  logic                      stop,
  input  logic                      clear,
  input  logic                      filt_en,
  input  logic [15:0]               filt_lo,
  input  logic [15:0]               filt_hi,
  output logic                      rd_valid,
  input  logic                      rd_pop,
  output logic [15:0]               rd_addr,
  output logic [15:0]               rd_data,
  output logic                      rd_write,
  output logic [TS_WIDTH-1:0]       rd_ts,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      illegal,
  output logic [1:0]                state
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam bit          WRAP_EN = (WRAP != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_HALTED  = 2'b10
  } state_t;

  typedef struct packed {
    logic [15:0]         addr;
    logic [15:0]         data;
    logic                write;
    logic [TS_WIDTH-1:0] ts;
  } entry_t;

  state_t               r_state;
  state_t               w_state_nxt;
  entry_t               r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_nxt;
  logic                 r_valid;
  logic                 r_overflow;
  logic                 r_illegal;
  logic [TS_WIDTH-1:0]  r_ts;
  logic [1:0]           r_prev_ctrl;
  logic [15:0]          r_prev_addr;

  logic   w_is_xfer;
  logic   w_event;
  logic   w_in_win;
  logic   w_accept;
  logic   w_full;
  logic   w_pop;
  logic   w_capture;
  logic   w_drop;
  logic   w_head_adv;
  logic   w_set_ovf;
  entry_t w_wr_entry;
  entry_t w_head;

  // A held transaction is one event; a new type or a new address starts another.
  assign w_is_xfer  = (ctrl_in == 2'b01) || (ctrl_in == 2'b10);
  assign w_event    = w_is_xfer && ((ctrl_in != r_prev_ctrl) || (addr_in != r_prev_addr));
  assign w_in_win   = (filt_lo <= addr_in) && (addr_in <= filt_hi);
  assign w_accept   = w_event && (!filt_en || w_in_win);

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_pop      = rd_pop && (r_count != '0);
  assign w_capture  = (r_state == ST_CAPTURE) && w_accept && (!w_full || WRAP_EN);
  assign w_drop     = w_accept && ((r_state == ST_HALTED) ||
                                   ((r_state == ST_CAPTURE) && w_full && !WRAP_EN));
  // When full, a capture always moves the head: either the pop or the overwrite frees it.
  assign w_head_adv = w_pop || (w_capture && w_full);
  assign w_set_ovf  = w_drop || (w_capture && w_full && !w_pop);

  assign w_wr_entry = '{addr: addr_in, data: data_in, write: ctrl_in[1], ts: r_ts};

  always_comb begin
    w_count_nxt = r_count;
    if (w_capture && !w_full && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_capture && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arm) w_state_nxt = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (stop) begin
            w_state_nxt = ST_IDLE;
          end else if (!WRAP_EN && (w_count_nxt == CNT_W'(DEPTH))) begin
            w_state_nxt = ST_HALTED;
          end
        end
        ST_HALTED: w_state_nxt = ST_HALTED;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_illegal   <= 1'b0;
      r_ts        <= '0;
      r_prev_ctrl <= 2'b00;
      r_prev_addr <= '0;
    end else begin
      r_ts        <= r_ts + TS_WIDTH'(1);
      r_prev_ctrl <= ctrl_in;
      r_prev_addr <= addr_in;
      if (clear) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_valid    <= 1'b0;
        r_overflow <= 1'b0;
        r_illegal  <= 1'b0;
      end else begin
        if (w_capture)  r_wptr <= r_wptr + PTR_W'(1);
        if (w_head_adv) r_rptr <= r_rptr + PTR_W'(1);
        r_count <= w_count_nxt;
        r_valid <= (w_count_nxt != '0);
        if (w_set_ovf) r_overflow <= 1'b1;
        if ((r_state == ST_CAPTURE) && (ctrl_in == 2'b11)) r_illegal <= 1'b1;
      end
    end
  end

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (w_capture && !clear && !reset) begin
      r_mem[r_wptr] <= w_wr_entry;
    end
  end

  assign w_head   = r_mem[r_rptr];
  assign rd_valid = r_valid;
  assign rd_addr  = w_head.addr;
  assign rd_data  = w_head.data;
  assign rd_write = w_head.write;
  assign rd_ts    = w_head.ts;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign illegal  = r_illegal;
  assign state    = r_state;

endmodule

// File: tb/tb_bus_trace_buffer.sv
// Self-checking bench for bus_trace_buffer: a WRAP=0 and a WRAP=1 instance share stimulus.
module tb_bus_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr_in;
  logic [1:0]  ctrl_in;
  logic [15:0] data_in;
  logic        arm, stop, clear, filt_en, rd_pop;
  logic [15:0] filt_lo, filt_hi;

  logic        d0_valid, d0_write, d0_ovf, d0_ill;
  logic [15:0] d0_addr, d0_data, d0_ts;
  logic [4:0]  d0_count;
  logic [1:0]  d0_state;
  logic        d1_valid, d1_write, d1_ovf, d1_ill;
  logic [15:0] d1_addr, d1_data, d1_ts;
  logic [4:0]  d1_count;
  logic [1:0]  d1_state;

  always #5 clk = ~clk;

  bus_trace_buffer #(.DEPTH(16), .TS_WIDTH(16), .WRAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .addr_in(addr_in), .ctrl_in(ctrl_in), .data_in(data_in),
    .arm(arm), .stop(stop), .clear(clear), .filt_en(filt_en), .filt_lo(filt_lo),
    .filt_hi(filt_hi), .rd_valid(d0_valid), .rd_pop(rd_pop), .rd_addr(d0_addr),
    .rd_data(d0_data), .rd_write(d0_write), .rd_ts(d0_ts), .count(d0_count),
    .overflow(d0_ovf), .illegal(d0_ill), .state(d0_state));

  bus_trace_buffer #(.DEPTH(16), .TS_WIDTH(16), .WRAP(1)) u_dut1 (
    .clk(clk), .reset(reset), .addr_in(addr_in), .ctrl_in(ctrl_in), .data_in(data_in),
    .arm(arm), .stop(stop), .clear(clear), .filt_en(filt_en), .filt_lo(filt_lo),
    .filt_hi(filt_hi), .rd_valid(d1_valid), .rd_pop(rd_pop), .rd_addr(d1_addr),
    .rd_data(d1_data), .rd_write(d1_write), .rd_ts(d1_ts), .count(d1_count),
    .overflow(d1_ovf), .illegal(d1_ill), .state(d1_state));

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        wr;
    logic [15:0] ts;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic        fen;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        stored;
  } vec_t;

  exp_t        sb[$];
  vec_t        tv[8];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] tb_ts;
  logic [15:0] t0;
  int          exp_cnt;

  // Free-running reference timestamp, same reset behaviour as the block.
  always @(posedge clk) begin
    if (reset) tb_ts <= 16'd0;
    else       tb_ts <= tb_ts + 16'd1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else             n_pass++;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] d, input logic wr,
                      input logic [15:0] ts);
    exp_t e;
    e = '{addr: a, data: d, wr: wr, ts: ts};
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] c, input logic [15:0] a, input logic [15:0] d,
                       input int n, input bit store);
    ctrl_in = c;
    addr_in = a;
    data_in = d;
    if (store) push(a, d, (c == 2'b10), tb_ts);
    step(n);
  endtask

  task automatic clear_arm();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    arm   = 1'b1;
    step(1);
    arm   = 1'b0;
  endtask

  // Pop every expected entry from instance 0 and compare against the scoreboard.
  task automatic drain0();
    int n;
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e = sb.pop_front();
      chk("drain_valid", 32'(d0_valid), 32'd1);
      chk("drain_addr",  32'(d0_addr),  32'(e.addr));
      chk("drain_data",  32'(d0_data),  32'(e.data));
      chk("drain_write", 32'(d0_write), 32'(e.wr));
      chk("drain_ts",    32'(d0_ts),    32'(e.ts));
      rd_pop = 1'b1;
      step(1);
      rd_pop = 1'b0;
    end
    chk("drain_empty", 32'(d0_valid), 32'd0);
    rd_pop = 1'b1;
    step(1);
    rd_pop = 1'b0;
    chk("empty_pop_count", 32'(d0_count), 32'd0);
  endtask

  initial begin
    reset = 1'b1; ctrl_in = 2'b00; addr_in = 16'h0; data_in = 16'h0;
    arm = 1'b0; stop = 1'b0; clear = 1'b0; rd_pop = 1'b0;
    filt_en = 1'b0; filt_lo = 16'h0; filt_hi = 16'h0;

    tv[0] = '{16'h7FFF, 1'b1, 16'h8000, 16'h80FF, 1'b0};
    tv[1] = '{16'h8000, 1'b1, 16'h8000, 16'h80FF, 1'b1};
    tv[2] = '{16'h80FF, 1'b1, 16'h8000, 16'h80FF, 1'b1};
    tv[3] = '{16'h8100, 1'b1, 16'h8000, 16'h80FF, 1'b0};
    tv[4] = '{16'h8080, 1'b1, 16'h9000, 16'h8000, 1'b0};
    tv[5] = '{16'h0000, 1'b0, 16'h8000, 16'h80FF, 1'b1};
    tv[6] = '{16'hFFFF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1};
    tv[7] = '{16'h1234, 1'b1, 16'h1234, 16'h1233, 1'b0};

    step(2);
    chk("rst_state", 32'(d0_state), 32'd0);
    chk("rst_count", 32'(d0_count), 32'd0);
    chk("rst_valid", 32'(d0_valid), 32'd0);
    chk("rst_ovf",   32'(d0_ovf),   32'd0);
    chk("rst_ill",   32'(d0_ill),   32'd0);
    reset = 1'b0;
    step(1);

    // Held read recorded once, then a single-cycle write.
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    chk("armed_state", 32'(d0_state), 32'd1);
    t0 = tb_ts;
    drive(2'b01, 16'h0100, 16'h1111, 3, 1'b1);
    push(16'h0102, 16'hBEEF, 1'b1, t0 + 16'd3);
    drive(2'b10, 16'h0102, 16'hBEEF, 1, 1'b0);
    drive(2'b00, 16'h0102, 16'h0000, 1, 1'b0);
    chk("basic_count", 32'(d0_count), 32'd2);
    drain0();

    // Address window filter table.
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      filt_en = tv[i].fen;
      filt_lo = tv[i].lo;
      filt_hi = tv[i].hi;
      drive(2'b01, tv[i].addr, 16'h2000 + 16'(i), 1, tv[i].stored);
      drive(2'b00, tv[i].addr, 16'h0000, 1, 1'b0);
      if (tv[i].stored) exp_cnt++;
      chk($sformatf("filt_count_%0d", i), 32'(d0_count), 32'(exp_cnt));
    end
    filt_en = 1'b0;
    drain0();

    // Stop in the same cycle as an event still captures it.
    stop = 1'b1;
    drive(2'b10, 16'h0055, 16'h5555, 1, 1'b1);
    stop = 1'b0;
    chk("stop_state", 32'(d0_state), 32'd0);
    chk("stop_count", 32'(d0_count), 32'd1);
    drive(2'b00, 16'h0055, 16'h0000, 1, 1'b0);
    drain0();

    // No-wrap fill: halt at 16, drop the 17th, drain in order.
    clear_arm();
    for (int i = 1; i <= 17; i++) begin
      drive(2'b10, 16'(i), ~16'(i), 1, (i <= 16));
      if (i == 16) begin
        chk("halt_state", 32'(d0_state), 32'd2);
        chk("halt_ovf0",  32'(d0_ovf),   32'd0);
      end
    end
    chk("halt_ovf1",  32'(d0_ovf),   32'd1);
    chk("halt_count", 32'(d0_count), 32'd16);
    drive(2'b00, 16'h0000, 16'h0000, 1, 1'b0);
    drain0();
    chk("halt_sticky", 32'(d0_state), 32'd2);

    // Wrap mode: overwrite oldest, then pop-every-cycle never overflows.
    clear_arm();
    chk("clr_ovf0", 32'(d0_ovf), 32'd0);
    for (int i = 1; i <= 20; i++) drive(2'b10, 16'(i), 16'h0, 1, 1'b0);
    drive(2'b00, 16'h0000, 16'h0000, 1, 1'b0);
    chk("wrap_count", 32'(d1_count), 32'd16);
    chk("wrap_ovf",   32'(d1_ovf),   32'd1);
    chk("wrap_head",  32'(d1_addr),  32'd5);
    clear_arm();
    rd_pop = 1'b1;
    for (int i = 1; i <= 20; i++) drive(2'b10, 16'(i), 16'h0, 1, 1'b0);
    rd_pop = 1'b0;
    drive(2'b00, 16'h0000, 16'h0000, 1, 1'b0);
    chk("wrappop_ovf",   32'(d1_ovf),   32'd0);
    chk("wrappop_count", 32'(d1_count), 32'd1);
    chk("wrappop_head",  32'(d1_addr),  32'd20);

    // Event and pop in the same cycle, then an illegal cycle.
    clear_arm();
    drive(2'b10, 16'h0010, 16'hA010, 1, 1'b1);
    drive(2'b10, 16'h0020, 16'hA020, 1, 1'b1);
    drive(2'b10, 16'h0030, 16'hA030, 1, 1'b1);
    drive(2'b00, 16'h0030, 16'h0000, 1, 1'b0);
    chk("sim_pre_count", 32'(d0_count), 32'd3);
    chk("sim_pre_head",  32'(d0_addr),  32'h0010);
    void'(sb.pop_front());
    rd_pop = 1'b1;
    drive(2'b10, 16'h0040, 16'hA040, 1, 1'b1);
    rd_pop = 1'b0;
    chk("sim_count", 32'(d0_count), 32'd3);
    chk("sim_head",  32'(d0_addr),  32'h0020);
    drive(2'b11, 16'h0040, 16'h0000, 1, 1'b0);
    chk("ill_set",   32'(d0_ill),   32'd1);
    chk("ill_count", 32'(d0_count), 32'd3);
    drive(2'b00, 16'h0040, 16'h0000, 1, 1'b0);
    drain0();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_ill",   32'(d0_ill),   32'd0);
    chk("clr_count", 32'(d0_count), 32'd0);
    chk("clr_state", 32'(d0_state), 32'd0);

    // Reset in the middle of a capture.
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    drive(2'b10, 16'h0A00, 16'h0, 1, 1'b0);
    drive(2'b10, 16'h0A01, 16'h0, 1, 1'b0);
    chk("mid_count", 32'(d0_count), 32'd2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mid_rst_count", 32'(d0_count), 32'd0);
    chk("mid_rst_state", 32'(d0_state), 32'd0);
    chk("mid_rst_valid", 32'(d0_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
